if_id_skid_reg: RTL
===================

Name: if_id_skid_reg

Overview:
- IF/ID pipeline register with a 2-entry skid buffer, sitting between instruction fetch and the IW_MUX instruction-word select.
- Registers fetched instruction/PC pairs and absorbs decode stalls without a combinational ready path back to fetch.
- Drops wrong-path instructions on flush.
- Generates the 2-bit select that steers the IW mux: 0 = fetched word, 1 = NOP bubble, 2 = killed/zero word.

Parameters:
- XLEN, 32, width of instruction word and PC.
- RST_PC, 32'h0000_0000, value driven on id_pc after reset.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- if_valid  input  1  fetch presents a valid instr/pc this cycle.
- if_instr  input  XLEN  fetched instruction word.
- if_pc  input  XLEN  PC of if_instr.
- if_ready  output  1  buffer can accept; transfer when if_valid & if_ready.
- id_ready  input  1  decode consumes head this cycle (stall = 0).
- flush  input  1  branch/jump redirect; kill all buffered and incoming instructions.
- id_valid  output  1  head entry valid.
- id_instr  output  XLEN  head instruction word (feeds IW mux in1).
- id_pc  output  XLEN  head PC.
- iw_sel  output  2  IW mux select: 0 fetched, 1 NOP, 2 killed.

Behaviour:
- Storage: head slot (H) and skid slot (S), each with a valid bit. FSM is count-based: EMPTY (no valid), ONE (H only), FULL (H and S). S is never valid while H is invalid.
- Reset (rst_n low, async):
  - H and S invalid; state EMPTY.
  - id_valid=0, id_instr=0, id_pc=RST_PC.
  - iw_sel=2'd1, if_ready=1.
- if_ready = ~S.valid. It is driven from a register only, with no path from id_ready or if_valid.
- acc = if_valid & if_ready; pop = id_valid & id_ready.
- Transitions when flush=0:
  - EMPTY: acc loads H, next state ONE.
  - ONE:
    - pop & acc: H <= incoming, stay ONE.
    - pop & !acc: go to EMPTY.
    - !pop & acc: S <= incoming, go to FULL.
    - !pop & !acc: hold.
  - FULL: acc is impossible. On pop, H <= S, S invalidated, go to ONE. Otherwise hold.
- Latency: an accepted instruction appears on id_* the next cycle when EMPTY, or the cycle after the preceding pop when not. Order is strictly FIFO.
- Flush (synchronous, highest priority):
  - H and S are invalidated and the next state is EMPTY, regardless of pop or acc.
  - An instruction accepted in the flush cycle is discarded; no duplicates or losses occur beyond that.
- Data registers are not cleared on invalidate. id_instr and id_pc hold their last value while id_valid=0.
- iw_sel, registered:
  - 2'd2 for exactly the one cycle after a flush.
  - Otherwise 2'd0 when H is valid, and 2'd1 when H is invalid.
  - 2'd3 is never generated.
- Reset mid-operation discards all contents immediately, without waiting for a clock edge.

Optional Feature:
- Macro IFID_PERF_EN.
- When defined, adds these outputs:
  - stall_cnt (32 bits): increments each cycle id_valid & !id_ready.
  - flush_cnt (32 bits): increments each cycle flush=1.
  - full_cnt (32 bits): increments each cycle state is FULL.
- All counters reset to 0, wrap modulo 2^32, and are unaffected by flush.
- When undefined, the ports and logic are absent and the block behaves otherwise identically.

Test Plan:
- Reset release, no if_valid → id_valid=0, iw_sel=1, if_ready=1, id_pc=RST_PC.
- Stream pc=0x00,0x04,0x08 with id_ready=1 → each appears on id_pc one cycle after accept, iw_sel=0, if_ready stays 1.
- Hold id_ready=0 and offer pc=0x10,0x14,0x18 → 0x10 in H and 0x14 in S, if_ready drops to 0, 0x18 is held by fetch. Release id_ready → order is 0x10,0x14,0x18.
- FULL state plus flush=1 together with id_ready=1 → next cycle id_valid=0, iw_sel=2, if_ready=1. The following cycle iw_sel=1 and no old PC reappears.
- Accept instr 0x00000013 at pc=0x20 in the same cycle as flush → instruction dropped; the next accepted pc=0x40 appears as the only output.
- Assert rst_n low while FULL, mid-cycle → outputs return to reset values before the next clk edge. With IFID_PERF_EN, all counters read 0.

Source files
------------

// File: rtl/if_id_skid_if.sv
// IF/ID handshake bundle: fetch-side offer, decode-side consume, redirect flush
// and the head entry presented to the IW mux.
interface if_id_skid_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            if_ready;
  logic            id_ready;
  logic            flush;
  logic            id_valid;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic [1:0]      iw_sel;

  modport master (
    output if_valid, if_instr, if_pc, id_ready, flush,
    input  if_ready, id_valid, id_instr, id_pc, iw_sel
  );

  modport slave (
    input  if_valid, if_instr, if_pc, id_ready, flush,
    output if_ready, id_valid, id_instr, id_pc, iw_sel
  );
endinterface

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer and IW mux select generation.
// Optional macro IFID_PERF_EN adds stall/flush/full performance counters.
module if_id_skid_reg #(
  parameter int              XLEN   = 32,
  parameter logic [XLEN-1:0] RST_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef IFID_PERF_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] full_cnt,
`endif
  if_id_skid_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic [XLEN-1:0] h_instr_r;
  logic [XLEN-1:0] h_pc_r;
  logic [XLEN-1:0] s_instr_r;
  logic [XLEN-1:0] s_pc_r;
  logic            id_valid_r;
  logic            if_ready_r;
  logic [1:0]      iw_sel_r;

  logic            acc_s;
  logic            pop_s;
  logic            h_ld_s;
  logic            h_from_s_s;
  logic            s_ld_s;
  logic            id_valid_nx_s;
  logic            if_ready_nx_s;
  logic [1:0]      iw_sel_nx_s;

  // if_ready comes from a flop, so fetch never sees a combinational path from decode
  assign acc_s = bus.if_valid & if_ready_r;
  assign pop_s = id_valid_r & bus.id_ready;

  assign bus.if_ready = if_ready_r;
  assign bus.id_valid = id_valid_r;
  assign bus.id_instr = h_instr_r;
  assign bus.id_pc    = h_pc_r;
  assign bus.iw_sel   = iw_sel_r;

  // Next-state and slot load decode; flush overrides every other transition
  always_comb begin
    state_nx_s = state_r;
    h_ld_s     = 1'b0;
    h_from_s_s = 1'b0;
    s_ld_s     = 1'b0;
    if (bus.flush) begin
      state_nx_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (acc_s) begin
            h_ld_s     = 1'b1;
            state_nx_s = ST_ONE;
          end else begin
            state_nx_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (pop_s && acc_s) begin
            h_ld_s     = 1'b1;
            state_nx_s = ST_ONE;
          end else if (pop_s) begin
            state_nx_s = ST_EMPTY;
          end else if (acc_s) begin
            s_ld_s     = 1'b1;
            state_nx_s = ST_FULL;
          end else begin
            state_nx_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (pop_s) begin
            h_from_s_s = 1'b1;
            state_nx_s = ST_ONE;
          end else begin
            state_nx_s = ST_FULL;
          end
        end
        default: begin
          state_nx_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Registered handshake outputs and IW select derived from the next state
  always_comb begin
    id_valid_nx_s = (state_nx_s != ST_EMPTY);
    if_ready_nx_s = (state_nx_s != ST_FULL);
    if (bus.flush) begin
      iw_sel_nx_s = 2'd2;
    end else if (state_nx_s != ST_EMPTY) begin
      iw_sel_nx_s = 2'd0;
    end else begin
      iw_sel_nx_s = 2'd1;
    end
  end

  // State and output flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_EMPTY;
      id_valid_r <= 1'b0;
      if_ready_r <= 1'b1;
      iw_sel_r   <= 2'd1;
    end else begin
      state_r    <= state_nx_s;
      id_valid_r <= id_valid_nx_s;
      if_ready_r <= if_ready_nx_s;
      iw_sel_r   <= iw_sel_nx_s;
    end
  end

  // Slot data; left untouched on invalidate so id_* holds its last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_instr_r <= {XLEN{1'b0}};
      h_pc_r    <= RST_PC;
      s_instr_r <= {XLEN{1'b0}};
      s_pc_r    <= {XLEN{1'b0}};
    end else begin
      if (h_ld_s) begin
        h_instr_r <= bus.if_instr;
        h_pc_r    <= bus.if_pc;
      end else if (h_from_s_s) begin
        h_instr_r <= s_instr_r;
        h_pc_r    <= s_pc_r;
      end
      if (s_ld_s) begin
        s_instr_r <= bus.if_instr;
        s_pc_r    <= bus.if_pc;
      end
    end
  end

`ifdef IFID_PERF_EN
  // Free-running wrap-around event counters, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
      full_cnt  <= 32'd0;
    end else begin
      if (id_valid_r && !bus.id_ready) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (bus.flush) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
      if (state_r == ST_FULL) begin
        full_cnt <= full_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
